uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver for the UART-to-I2C bridge. It supports configurable bit divisor, data width, parity and stop bits, and uses majority-vote mid-bit sampling with false-start rejection. Each received word is presented on a valid/ready output with per-word error flags, which lets the bridge core stall without losing framing. It sits between the external RX pin and the bridge command parser.

## Interface
- CLK_DIV, 10416: clock cycles per bit (SYSCLK/baud); legal range ≥ 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports (clock and reset first):
- clock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  1  serial RX line, asynchronous, idle high.
- out_data  out  DATA_BITS  received word, LSB = first data bit on the wire.
- out_valid  out  1  word available; held until accepted.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- parity_err  out  1  parity mismatch for the word on out_data (always 0 when PARITY = 0).
- frame_err  out  1  a stop bit was sampled 0 for this word.
- break_det  out  1  all data bits 0, parity (if any) 0, and frame_err set.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Input path: 2-flop synchronizer. Its flops reset to 1.
- Bit timer cnt, width $clog2(CLK_DIV), runs 0..CLK_DIV-1 and restarts at 0 on every bit boundary.
- Mid-bit sampling: samples taken at cnt = M-1, M, M+1, where M = CLK_DIV/2 (integer divide). The bit value is the majority of the 3 samples and is decided at cnt = M+1.
- FSM states and transitions:
  - IDLE: go to START when the synchronized line is 0. That same cycle is cnt = 0 of the start bit.
  - START: if the voted value is 1, return to IDLE at cnt = M+1 (false start; nothing is output). Otherwise go to DATA at cnt = CLK_DIV-1.
  - DATA: shift voted bits LSB-first. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, else go to STOP.
  - PARITY: compare the voted bit with the XOR of the data bits. Odd mode requires total ones to be odd; even mode requires total ones to be even.
  - STOP: the first stop bit runs a full CLK_DIV. The last stop bit ends at cnt = M+1. A stop sampled 0 sets frame_err for the word.
- At the last stop bit decision (cnt = M+1) the FSM returns to IDLE. It is rearmed half a bit early so it can resync on back-to-back frames.
- Delivery happens at the last-stop decision cycle:
  - If out_valid = 0, or out_valid && out_ready in the same cycle: load out_data and the three error flags, and out_valid = 1 on the next cycle.
  - If out_valid && !out_ready: discard the new word, pulse overrun for one cycle, and leave the held word and flags unchanged.
- Handshake: out_valid && out_ready with no simultaneous delivery clears out_valid next cycle. out_data and the flags stay stable while out_valid = 1.
- Reset (asynchronous, any time including mid-frame): FSM goes to IDLE and cnt = 0. out_data = 0, out_valid = 0, parity_err = frame_err = break_det = overrun = 0, and the synchronizer is set to 1. The frame in progress is lost. The first start is detected after rst_n rises and the line is seen low.

## Timing
- Pin to synchronized line: 2 clocks.
- Frame length N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits.
- out_valid rises (N-1)·CLK_DIV + M + 2 clocks after START is entered. START entry is 2 clocks after the pin falls (aligned to the edge).
- False start returns to IDLE M+1 clocks after START entry.
- Sample alignment tolerance: ±(M-1) clocks of bit-edge skew per frame.
- overrun is exactly 1 clock wide. out_valid never drops without a handshake.

## Test plan
- CLK_DIV = 16, DATA_BITS = 8, PARITY = 2, STOP_BITS = 1. Send 0xA5 with parity 0 and stop 1 -> out_data = 0xA5; out_valid rises 172 clocks after the pin falls; all flags 0.
- Same configuration. Send 0x3C with parity bit 1 -> out_data = 0x3C, parity_err = 1, frame_err = 0.
- Pin low for 4 clocks, then high -> no out_valid. A following 0x55 frame is received correctly.
- Send 0x00 with parity 0 and stop 0 -> frame_err = 1, break_det = 1. Send 0x81 with stop 0 -> frame_err = 1, break_det = 0.
- out_ready = 0; send 0x11 then 0x22 back-to-back -> out_data holds 0x11 and overrun pulses once. Next, assert out_ready exactly at the 0x33 delivery cycle -> out_data = 0x33, out_valid stays 1, no overrun.
- Assert rst_n = 0 mid-data-bit 4 -> all outputs 0 asynchronously. After release, send 0x7E -> received correctly with no residue from the aborted frame.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority vote,
// false-start rejection and a valid/ready word output with error flags.
module uart_rx_param #(
    parameter int CLK_DIV   = 10416,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int M  = CLK_DIV / 2;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] S_LO   = CW'(M - 1);
    localparam logic [CW-1:0] S_MID  = CW'(M);
    localparam logic [CW-1:0] S_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] S_END  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic                 sync1, line;
    logic [CW-1:0]        cnt;
    logic                 smp0, smp1, vote;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr_acc;
    logic                 dec, bend, last_stop, deliver;
    logic                 ones_odd, perr_w, ferr_w, brk_w;

    assign dec       = (cnt == S_DEC);
    assign bend      = (cnt == S_END);
    assign vote      = (smp0 & smp1) | (smp0 & line) | (smp1 & line);
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    assign ones_odd = (^shreg) ^ par_bit;
    assign perr_w   = (PARITY == 1) ? ~ones_odd :
                      (PARITY == 2) ?  ones_odd : 1'b0;
    assign ferr_w   = ferr_acc | ~vote;
    assign brk_w    = (shreg == '0) && !par_bit && ferr_w;

    // Two-flop synchronizer; idles high so reset never looks like a start.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= in;
            line  <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state; the last stop decision rearms half a bit early.
    always_comb begin
        state_n = state;
        deliver = 1'b0;
        unique case (state)
            IDLE:  if (!line) state_n = START;
            START: begin
                if (dec && vote) state_n = IDLE;
                else if (bend)   state_n = DATA;
            end
            DATA:  if (bend && bit_idx == B_LAST)
                       state_n = (PARITY != 0) ? PAR : STOP;
            PAR:   if (bend) state_n = STOP;
            STOP:  if (dec && last_stop) begin
                       state_n = IDLE;
                       deliver = 1'b1;
                   end
            default: state_n = IDLE;
        endcase
    end

    // Bit timer, mid-bit samples and frame accumulation.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= line ? '0 : CW'(1);
            else if (state_n == IDLE || bend)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (cnt == S_LO)  smp0 <= line;
            if (cnt == S_MID) smp1 <= line;
            if (state == IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (state == DATA && dec)
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (state == DATA && bend)
                bit_idx <= bit_idx + BW'(1);
            if (state == PAR && dec)
                par_bit <= vote;
            if (state == STOP && dec && !vote)
                ferr_acc <= 1'b1;
            if (state == STOP && bend)
                stop_idx <= 1'b1;
        end
    end

    // Output word holding register with overrun on a blocked delivery.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!out_valid || out_ready) begin
                    out_data   <= shreg;
                    parity_err <= perr_w;
                    frame_err  <= ferr_w;
                    break_det  <= brk_w;
                    out_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
